// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared loader state encoding and instruction-memory geometry.
// Contents : state_t    - loader FSM states
//            IMEM_DEPTH - instruction memory depth in words
//            IMEM_AW    - instruction memory word-address width
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  localparam int IMEM_DEPTH = 64;
  localparam int IMEM_AW    = 6;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    WORD   = 3'd2,
    CHK    = 3'd3,
    RUN    = 3'd4,
    ERR    = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Purpose  : Packs four MSB-first bytes into a 32-bit word.
// Ports    : clk, rst         - clock, async active-high reset
//            clear            - synchronous clear of byte index and shifter
//            in_byte/in_valid - accepted stream byte
//            word_valid       - high in the cycle the 4th byte is presented
//            word             - assembled word (valid with word_valid)
// Revision : 1.0 - initial release
// ============================================================================
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shift;
  logic [1:0]  idx;

  // The 4th byte is combined with the three held bytes combinationally so
  // the consumer can register the finished word on the accepting edge.
  assign word_valid = in_valid && (idx == 2'd3);
  assign word       = {shift, in_byte};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      idx   <= '0;
    end else if (clear) begin
      shift <= '0;
      idx   <= '0;
    end else if (in_valid) begin
      shift <= {shift[15:0], in_byte};
      idx   <= idx + 2'd1;   // wraps to 0 after the 4th byte
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Byte-stream program loader. Writes a counted, XOR-checksummed
//            image into instruction memory and holds the core in reset until
//            the whole image has been written and verified.
// Ports    : clk, rst               - clock, async active-high reset
//            in_data/in_valid       - stream byte input
//            in_ready               - byte accepted when in_valid & in_ready
//            reload                 - pulse: abort and restart loading
//            imem_we/addr/data      - instruction memory write port
//            core_rst               - core reset (1 = held)
//            done / err             - load verified / load failed
//            words_loaded           - words written in the current load
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               reload,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_data,
  output logic               core_rst,
  output logic               done,
  output logic               err,
  output logic [6:0]         words_loaded
);

  state_t      state, next_state;
  logic [7:0]  cnt_hi;
  logic [6:0]  count;
  logic [7:0]  xor_acc;

  logic        accept;
  logic [15:0] hdr_count;
  logic        oversize;
  logic        chk_ok;
  logic        last_word;
  logic        word_valid;
  logic [31:0] word;

  assign in_ready  = !reload && (state == HDR_HI || state == HDR_LO ||
                                 state == WORD   || state == CHK);
  assign accept    = in_valid && in_ready;
  assign hdr_count = {cnt_hi, in_data};
  assign oversize  = hdr_count > 16'(DEPTH);
  assign chk_ok    = (in_data == xor_acc);
  assign last_word = (words_loaded + 7'd1) == count;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (reload),
    .in_byte    (in_data),
    .in_valid   (accept && state == WORD),
    .word_valid (word_valid),
    .word       (word)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HDR_HI;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (reload) begin
      next_state = HDR_HI;
    end else begin
      case (state)
        HDR_HI: if (accept) next_state = HDR_LO;
        HDR_LO: if (accept) begin
          if (hdr_count == 16'd0) next_state = CHK;
          else if (oversize)      next_state = ERR;
          else                    next_state = WORD;
        end
        WORD:   if (word_valid && last_word) next_state = CHK;
        CHK:    if (accept) next_state = chk_ok ? RUN : ERR;
        default: next_state = state;   // RUN and ERR hold until reload
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_hi       <= '0;
      count        <= '0;
      xor_acc      <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_data    <= '0;
      core_rst     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (reload) begin
        words_loaded <= '0;
        xor_acc      <= '0;
        done         <= 1'b0;
        err          <= 1'b0;
        core_rst     <= 1'b1;
      end else begin
        // The checksum byte itself is not folded into the running XOR.
        if (accept && state != CHK) xor_acc <= xor_acc ^ in_data;

        if (accept && state == HDR_HI) cnt_hi <= in_data;

        if (accept && state == HDR_LO) begin
          count <= oversize ? 7'd0 : hdr_count[6:0];
          if (oversize) err <= 1'b1;
        end

        if (word_valid) begin
          imem_we   <= 1'b1;
          imem_addr <= words_loaded[IMEM_AW-1:0];
          imem_data <= word;
          if (words_loaded < count) words_loaded <= words_loaded + 7'd1;
        end

        if (accept && state == CHK) begin
          if (chk_ok) begin
            done     <= 1'b1;
            core_rst <= 1'b0;
          end else begin
            err      <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed self-checking bench for imem_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        reload;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        core_rst;
  logic        done;
  logic        err;
  logic [6:0]  words_loaded;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .core_rst     (core_rst),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  // Write log captured mid-cycle
  logic [5:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_data);
    end
  end

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] img [64];
  logic [7:0]  xacc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    xacc     = xacc ^ b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
  endfunction

  task automatic send_image(input int n, input int maxgap, input logic [7:0] flip);
    logic [7:0] chk;
    xacc = 8'h00;
    send_byte(8'(n >> 8), pick_gap(maxgap));
    send_byte(8'(n), pick_gap(maxgap));
    for (int w = 0; w < n; w++)
      for (int k = 3; k >= 0; k--)
        send_byte(img[w][8*k +: 8], pick_gap(maxgap));
    chk = xacc ^ flip;
    send_byte(chk, pick_gap(maxgap));
  endtask

  // Reload pulse, optionally with a valid byte presented in the same cycle.
  task automatic do_reload(input string tag, input logic with_byte, input logic [7:0] b);
    reload   = 1'b1;
    in_valid = with_byte;
    in_data  = b;
    #1;
    check({tag, "_ready_blocked"}, 64'(in_ready), 64'h0);
    @(posedge clk); #1;
    reload   = 1'b0;
    in_valid = 1'b0;
    check({tag, "_core_rst"}, 64'(core_rst), 64'h1);
    check({tag, "_words"},    64'(words_loaded), 64'h0);
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),     64'h1);
    check({tag, "_we"},        64'(imem_we),      64'h0);
    check({tag, "_addr"},      64'(imem_addr),    64'h0);
    check({tag, "_data"},      64'(imem_data),    64'h0);
    check({tag, "_core_rst"},  64'(core_rst),     64'h1);
    check({tag, "_done"},      64'(done),         64'h0);
    check({tag, "_err"},       64'(err),          64'h0);
    check({tag, "_words"},     64'(words_loaded), 64'h0);
  endtask

  task automatic set_img3();
    img[0] = 32'h12345678;
    img[1] = 32'hDEADBEEF;
    img[2] = 32'h00C0FFEE;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; reload = 1'b0; in_valid = 1'b0; in_data = 8'h00; xacc = 8'h00;

    // ---- reset values, during and just after reset ----
    #12;
    check_reset_vals("rst_held");
    #5 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("rst_after");

    // ---- N=3, correct checksum (0xF8) ----
    set_img3();
    send_image(3, 0, 8'h00);
    check("n3_nwr", 64'(wr_data_q.size()), 64'd3);
    if (wr_data_q.size() == 3) begin
      check("n3_a0", 64'(wr_addr_q[0]), 64'd0);
      check("n3_a1", 64'(wr_addr_q[1]), 64'd1);
      check("n3_a2", 64'(wr_addr_q[2]), 64'd2);
      check("n3_d0", 64'(wr_data_q[0]), 64'h12345678);
      check("n3_d1", 64'(wr_data_q[1]), 64'hDEADBEEF);
      check("n3_d2", 64'(wr_data_q[2]), 64'h00C0FFEE);
    end
    check("n3_done",     64'(done),         64'h1);
    check("n3_core_rst", 64'(core_rst),     64'h0);
    check("n3_words",    64'(words_loaded), 64'd3);
    check("n3_ready",    64'(in_ready),     64'h0);
    check("n3_err",      64'(err),          64'h0);

    // ---- same stream, checksum ^ 0x01 ----
    do_reload("rl1", 1'b0, 8'h00);
    check("rl1_done", 64'(done), 64'h0);
    send_image(3, 0, 8'h01);
    check("bad_nwr",      64'(wr_data_q.size()), 64'd3);
    check("bad_err",      64'(err),      64'h1);
    check("bad_core_rst", 64'(core_rst), 64'h1);
    check("bad_done",     64'(done),     64'h0);
    check("bad_ready",    64'(in_ready), 64'h0);

    // ---- N=0 with checksum 0x00 ----
    do_reload("rl2", 1'b0, 8'h00);
    check("rl2_err", 64'(err), 64'h0);
    send_image(0, 0, 8'h00);
    check("n0_nwr",      64'(wr_data_q.size()), 64'd0);
    check("n0_done",     64'(done),     64'h1);
    check("n0_core_rst", 64'(core_rst), 64'h0);

    // ---- N=65: oversize ----
    do_reload("rl3", 1'b0, 8'h00);
    xacc = 8'h00;
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    check("ovr_err",      64'(err),      64'h1);
    check("ovr_ready",    64'(in_ready), 64'h0);
    check("ovr_core_rst", 64'(core_rst), 64'h1);
    repeat (3) @(posedge clk);
    #1;
    check("ovr_nwr",      64'(wr_data_q.size()), 64'd0);

    // ---- abort after 6th byte of a 2-word load, then fresh 1-word image ----
    do_reload("rl4", 1'b0, 8'h00);
    xacc = 8'h00;
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    check("abort_words_pre", 64'(words_loaded), 64'd1);
    do_reload("rl5", 1'b1, 8'hFF);   // byte presented with reload must be dropped
    img[0] = 32'hCAFEBABE;           // checksum 00^01^CA^FE^BA^BE = 0x31
    send_image(1, 0, 8'h00);
    check("fresh_nwr", 64'(wr_data_q.size()), 64'd1);
    if (wr_data_q.size() == 1) begin
      check("fresh_a0", 64'(wr_addr_q[0]), 64'd0);
      check("fresh_d0", 64'(wr_data_q[0]), 64'hCAFEBABE);
    end
    check("fresh_done",  64'(done),         64'h1);
    check("fresh_words", 64'(words_loaded), 64'd1);

    // ---- 64-word load with random idle gaps ----
    for (int i = 0; i < 64; i++)
      img[i] = {8'(i), 8'(8'hA5 ^ 8'(i)), 8'(3 * i), 8'(8'hFF - 8'(i))};
    do_reload("rl6", 1'b0, 8'h00);
    send_image(64, 5, 8'h00);
    check("n64_nwr", 64'(wr_data_q.size()), 64'd64);
    for (int i = 0; i < 64; i++) begin
      if (i < wr_data_q.size()) begin
        check($sformatf("n64_a%0d", i), 64'(wr_addr_q[i]), 64'(i));
        check($sformatf("n64_d%0d", i), 64'(wr_data_q[i]), 64'(img[i]));
      end
    end
    check("n64_done",  64'(done),         64'h1);
    check("n64_words", 64'(words_loaded), 64'd64);

    // ---- async reset mid-word ----
    set_img3();
    do_reload("rl7", 1'b0, 8'h00);
    xacc = 8'h00;
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'hA1, 0); send_byte(8'hB2, 0); send_byte(8'hC3, 0); send_byte(8'hD4, 0);
    send_byte(8'hE5, 0); send_byte(8'hF6, 0);
    check("arst_words_pre", 64'(words_loaded), 64'd1);
    check("arst_data_pre",  64'(imem_data),    64'hA1B2C3D4);
    #2 rst = 1'b1;                    // between clock edges
    #1;
    check_reset_vals("arst_held");
    #1 rst = 1'b0;
    @(posedge clk); #1;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_image(3, 0, 8'h00);
    check("arst_reload_nwr", 64'(wr_data_q.size()), 64'd3);
    if (wr_data_q.size() == 3)
      check("arst_reload_d2", 64'(wr_data_q[2]), 64'h00C0FFEE);
    check("arst_reload_done",  64'(done),         64'h1);
    check("arst_reload_words", 64'(words_loaded), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
